// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller.
//
// Issues one instruction-memory request per cycle while running and hands each
// accepted instruction to ID. An accepted fetch that lands while IF is stalled
// goes into a one-entry skid buffer. Branches and exception flushes redirect the
// fetch PC. A request that is still waiting for its ack keeps its address until
// the ack arrives; only the request after it uses the redirected PC.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall_req_id/ex           stall requests from ID / EX
//   branch_flag/target        taken branch resolved in ID
//   flush/new_pc              exception flush pulse and handler address
//   imem_req/addr             request to instruction memory
//   imem_ack/rdata            accept plus data, returned in the same cycle
//   pc                        next address to fetch
//   if_valid/if_pc/if_inst    instruction delivered to ID
//   stall                     combinational stall vector {wb,mem,ex,id,if,pc}
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_req_id,
    input  logic               stall_req_ex,
    input  logic               branch_flag,
    input  logic [31:0]        branch_target,
    input  logic               flush,
    input  logic [31:0]        new_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_inst,
    output logic [STALL_W-1:0] stall
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_addr_q, skid_addr_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic        drop_q, drop_d;
    // Redirect captured while a request is outstanding; applied when it acks.
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic [5:0]  stall_vec;
    logic        stall_if;
    logic        branch_ok;
    logic [31:0] pc_seq;

    always_comb begin
        stall_vec = 6'b000000;
        if (flush) begin
            stall_vec = 6'b000000;
        end else if (stall_req_ex) begin
            stall_vec = 6'b001111;
        end else if (stall_req_id) begin
            stall_vec = 6'b000111;
        end
    end

    assign stall     = STALL_W'(stall_vec);
    assign stall_if  = stall_vec[1];
    assign branch_ok = branch_flag && !flush && !stall_vec[2];
    // Sequential successor, unless a branch was taken while this fetch was in flight.
    assign pc_seq    = redir_valid_q ? redir_pc_q : pc_q + 32'd4;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_inst_d     = if_inst_q;
        skid_valid_d  = skid_valid_q;
        skid_addr_d   = skid_addr_q;
        skid_data_d   = skid_data_q;
        drop_d        = drop_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;

        case (state_q)
            StIdle: begin
                state_d = StReq;
                if (flush) begin
                    pc_d       = new_pc;
                    if_valid_d = 1'b0;
                end else if (branch_ok) begin
                    pc_d = branch_target;
                end
            end

            StReq: begin
                if (flush) begin
                    if_valid_d = 1'b0;
                    if (imem_ack) begin
                        // Coincident ack is discarded; nothing left in flight.
                        pc_d          = new_pc;
                        drop_d        = 1'b0;
                        redir_valid_d = 1'b0;
                    end else begin
                        // Keep the address stable; drop the data when it arrives.
                        drop_d        = 1'b1;
                        redir_valid_d = 1'b1;
                        redir_pc_d    = new_pc;
                    end
                end else if (imem_ack) begin
                    redir_valid_d = 1'b0;
                    if (drop_q) begin
                        drop_d = 1'b0;
                        pc_d   = redir_pc_q;
                        if (!stall_if) begin
                            if_valid_d = 1'b0;
                        end
                    end else if (stall_if) begin
                        skid_valid_d = 1'b1;
                        skid_addr_d  = pc_q;
                        skid_data_d  = imem_rdata;
                        pc_d         = pc_seq;
                        state_d      = StHold;
                    end else begin
                        // Acked fetch is the delay slot if a branch is taken now.
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_inst_d  = imem_rdata;
                        pc_d       = branch_ok ? branch_target : pc_seq;
                    end
                end else begin
                    if (!stall_if) begin
                        if_valid_d = 1'b0;
                    end
                    if (branch_ok && !drop_q) begin
                        redir_valid_d = 1'b1;
                        redir_pc_d    = branch_target;
                    end
                end
            end

            StHold: begin
                if (flush) begin
                    if_valid_d   = 1'b0;
                    skid_valid_d = 1'b0;
                    pc_d         = new_pc;
                    state_d      = StReq;
                end else if (!stall_if) begin
                    if_valid_d   = skid_valid_q;
                    if_pc_d      = skid_addr_q;
                    if_inst_d    = skid_data_q;
                    skid_valid_d = 1'b0;
                    state_d      = StReq;
                    if (branch_ok) begin
                        pc_d = branch_target;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0;
            if_inst_q     <= 32'h0;
            skid_valid_q  <= 1'b0;
            skid_addr_q   <= 32'h0;
            skid_data_q   <= 32'h0;
            drop_q        <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
            skid_valid_q  <= skid_valid_d;
            skid_addr_q   <= skid_addr_d;
            skid_data_q   <= skid_data_d;
            drop_q        <= drop_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign imem_req  = (state_q == StReq);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: one task per scenario, inline checks.
module tb_ifetch_ctrl;

    localparam logic [31:0] K = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_req_id, stall_req_ex, branch_flag, flush, imem_ack;
    logic [31:0] branch_target, new_pc;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, imem_rdata, pc, if_pc, if_inst;
    logic [5:0]  stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory returns a word derived from the address so delivered data is traceable.
    assign imem_rdata = imem_addr ^ K;

    ifetch_ctrl #(.RESET_PC(32'h0000_0000), .STALL_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req_id (stall_req_id),
        .stall_req_ex (stall_req_ex),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .flush        (flush),
        .new_pc       (new_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .stall        (stall)
    );

    task automatic test_reset;
        rst = 1'b1; imem_ack = 1'b0; flush = 1'b0; branch_flag = 1'b0;
        stall_req_id = 1'b0; stall_req_ex = 1'b0; branch_target = '0; new_pc = '0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc); end
        checks++; if ({if_valid, if_pc, if_inst} !== 65'h0) begin failures++;
            $display("FAIL rst_if got=%b/%h/%h exp=0/0/0", if_valid, if_pc, if_inst); end
        checks++; if (stall !== 6'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++;
            $display("FAIL first_req got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_stream;
        imem_ack = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++; if (imem_addr !== 32'(4 * i)) begin failures++;
                $display("FAIL stream_addr%0d got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * (i - 1)) || if_inst !== (32'(4 * (i - 1)) ^ K)) begin
                failures++; $display("FAIL stream_if%0d got=%b/%h/%h exp=1/%h/%h", i, if_valid, if_pc, if_inst,
                                     32'(4 * (i - 1)), 32'(4 * (i - 1)) ^ K); end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_latency;
        logic [31:0] a;
        a = 32'h0C;
        for (int f = 0; f < 2; f++) begin
            imem_ack = 1'b0;
            for (int w = 0; w < 2; w++) begin
                @(negedge clk);
                checks++; if (imem_req !== 1'b1 || imem_addr !== a || if_valid !== 1'b0) begin failures++;
                    $display("FAIL lat_wait got=%b/%h/%b exp=1/%h/0", imem_req, imem_addr, if_valid, a); end
            end
            imem_ack = 1'b1;
            @(negedge clk);
            checks++; if (if_valid !== 1'b1 || if_pc !== a || if_inst !== (a ^ K) || imem_addr !== a + 32'd4) begin
                failures++; $display("FAIL lat_deliver got=%b/%h/%h exp=1/%h/%h", if_valid, if_pc, imem_addr,
                                     a, a + 32'd4); end
            a = a + 32'd4;
        end
    endtask

    task automatic test_stall;
        // Entry: request 0x14 presented, ID holds 0x10.
        imem_ack = 1'b1; stall_req_ex = 1'b1;
        #1;
        checks++; if (stall !== 6'b001111) begin failures++; $display("FAIL stall_ex_vec got=%b exp=001111", stall); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h10 || pc !== 32'h18) begin
                failures++; $display("FAIL stall_hold%0d got=%b/%b/%h/%h exp=0/1/00000010/00000018", c, imem_req,
                                     if_valid, if_pc, pc); end
        end
        stall_req_ex = 1'b0;
        #1;
        checks++; if (stall !== 6'b0) begin failures++; $display("FAIL stall_rel_vec got=%b exp=0", stall); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h14 || if_inst !== (32'h14 ^ K)) begin failures++;
            $display("FAIL skid_out got=%b/%h/%h exp=1/00000014/%h", if_valid, if_pc, if_inst, 32'h14 ^ K); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin failures++;
            $display("FAIL skid_resume got=%b/%h exp=1/00000018", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (if_pc !== 32'h18 || imem_addr !== 32'h1C) begin failures++;
            $display("FAIL skid_next got=%h/%h exp=00000018/0000001c", if_pc, imem_addr); end
    endtask

    task automatic test_branch;
        test_reset();
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (imem_addr !== 32'h0C) begin failures++; $display("FAIL br_pre got=%h exp=0000000c", imem_addr); end
        imem_ack = 1'b0; branch_flag = 1'b1; branch_target = 32'h100;
        @(negedge clk);
        branch_flag = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0C || if_valid !== 1'b0) begin failures++;
            $display("FAIL br_inflight got=%b/%h/%b exp=1/0000000c/0", imem_req, imem_addr, if_valid); end
        imem_ack = 1'b1;
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0C || imem_addr !== 32'h100) begin failures++;
            $display("FAIL br_slot got=%b/%h/%h exp=1/0000000c/00000100", if_valid, if_pc, imem_addr); end
        @(negedge clk);
        checks++; if (if_pc !== 32'h100 || imem_addr !== 32'h104) begin failures++;
            $display("FAIL br_target got=%h/%h exp=00000100/00000104", if_pc, imem_addr); end
    endtask

    task automatic test_flush;
        test_reset();
        imem_ack = 1'b1;
        repeat (8) @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        checks++; if (imem_addr !== 32'h20 || if_valid !== 1'b0) begin failures++;
            $display("FAIL fl_pending got=%h/%b exp=00000020/0", imem_addr, if_valid); end
        flush = 1'b1; new_pc = 32'h380; branch_flag = 1'b1; branch_target = 32'h500; stall_req_ex = 1'b1;
        #1;
        checks++; if (stall !== 6'b0) begin failures++; $display("FAIL fl_stall got=%b exp=0", stall); end
        @(negedge clk);
        flush = 1'b0; branch_flag = 1'b0; stall_req_ex = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || if_valid !== 1'b0) begin failures++;
            $display("FAIL fl_stable got=%b/%h/%b exp=1/00000020/0", imem_req, imem_addr, if_valid); end
        imem_ack = 1'b1;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h380) begin failures++;
            $display("FAIL fl_drop got=%b/%h exp=0/00000380", if_valid, imem_addr); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h380) begin failures++;
            $display("FAIL fl_handler got=%b/%h exp=1/00000380", if_valid, if_pc); end
        flush = 1'b1; new_pc = 32'h400;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h400) begin failures++;
            $display("FAIL fl_coinc got=%b/%h exp=0/00000400", if_valid, imem_addr); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h400) begin failures++;
            $display("FAIL fl_coinc_next got=%b/%h exp=1/00000400", if_valid, if_pc); end
    endtask

    task automatic test_wrap;
        flush = 1'b1; new_pc = 32'hFFFF_FFFC; imem_ack = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || pc !== 32'hFFFF_FFFC) begin failures++;
            $display("FAIL wrap_pre got=%h/%h exp=fffffffc", imem_addr, pc); end
        @(negedge clk);
        checks++; if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_inst !== (32'hFFFF_FFFC ^ K)) begin
            failures++; $display("FAIL wrap got=%h/%h/%h exp=00000000/fffffffc/%h", imem_addr, if_pc, if_inst,
                                 32'hFFFF_FFFC ^ K); end
        stall_req_id = 1'b1;
        #1;
        checks++; if (stall !== 6'b000111) begin failures++; $display("FAIL stall_id_vec got=%b exp=000111", stall); end
        stall_req_id = 1'b0; stall_req_ex = 1'b1;
        #1;
        checks++; if (stall !== 6'b001111) begin failures++; $display("FAIL stall_ex_only got=%b exp=001111", stall); end
        stall_req_ex = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_latency();
        test_stall();
        test_branch();
        test_flush();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, first fetch address after reset.
REQ-002 Parameter: STALL_W, 6, stall vector width; bits are [0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: stall_req_id  in  1  ID stage stall request.
REQ-006 Port: stall_req_ex  in  1  EX stage stall request.
REQ-007 Port: branch_flag  in  1  taken branch/jump resolved in ID.
REQ-008 Port: branch_target  in  32  redirect address for branch_flag.
REQ-009 Port: flush  in  1  exception flush, one-cycle pulse.
REQ-010 Port: new_pc  in  32  exception handler address for flush.
REQ-011 Port: imem_req  out  1  instruction memory request.
REQ-012 Port: imem_addr  out  32  request address.
REQ-013 Port: imem_ack  in  1  memory accept plus data valid, same cycle.
REQ-014 Port: imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-015 Port: pc  out  32  next address to fetch.
REQ-016 Port: if_valid  out  1  if_pc/if_inst carry a real instruction to ID.
REQ-017 Port: if_pc  out  32  PC of delivered instruction.
REQ-018 Port: if_inst  out  32  delivered instruction.
REQ-019 Port: stall  out  STALL_W  combinational pipeline stall vector.

Function
REQ-020 The stall vector SHALL be: flush -> 6'b000000; else stall_req_ex -> 6'b001111; else stall_req_id -> 6'b000111; else 6'b000000.
REQ-021 The FSM SHALL have states IDLE, REQ, HOLD; reset enters IDLE; IDLE -> REQ unconditionally on the next cycle.
REQ-022 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_addr SHALL stay stable while imem_req=1 and imem_ack=0, and a request SHALL never be withdrawn before ack.
REQ-023 On an imem_ack with stall[1]=0 and no drop pending, the block SHALL register if_valid=1, if_pc=imem_addr, and if_inst=imem_rdata; pc<=pc+4 (mod 2^32, wrap 32'hFFFFFFFC -> 0); it stays in REQ, giving back-to-back fetches at one instruction per ack.
REQ-024 In REQ with stall[1]=0 and no valid ack, the block SHALL register if_valid=0 (bubble), with if_pc and if_inst don't-care.
REQ-025 When stall[1]=1, the if_valid, if_pc and if_inst registers SHALL hold.
REQ-026 An ack arriving while stall[1]=1 SHALL be captured into a one-entry skid buffer (addr, data), with pc<=pc+4; the FSM goes to HOLD with imem_req=0.
REQ-027 In HOLD, when stall[1] returns to 0, the skid buffer SHALL move into the if_* registers with if_valid=1 in that cycle; the FSM returns to REQ the next cycle.
REQ-028 Precedence SHALL be: flush > stall_req_ex > stall_req_id > branch_flag > sequential.
REQ-029 branch_flag SHALL be honoured only when stall[2]=0: pc<=branch_target.
REQ-030 A fetch already acked or in flight when branch_flag is honoured is the delay slot; it SHALL be delivered, not dropped, and the next request uses branch_target.
REQ-031 On flush, the block SHALL set pc<=new_pc, if_valid<=0, clear the skid buffer, and move HOLD -> REQ.
REQ-032 If a request is outstanding (imem_req=1, no ack) when flush arrives, the block SHALL set a drop flag; the matching ack's data is discarded and the flag clears.
REQ-033 A flush coincident with an imem_ack SHALL discard that ack's data.
REQ-034 The next request after a drop SHALL use new_pc.
REQ-035 The new pc SHALL take effect in imem_addr only after the in-flight request completes.
REQ-036 A branch and a flush in the same cycle SHALL resolve to the flush only.

Reset
REQ-037 While rst=1 at a clock edge: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, skid empty, drop=0.
REQ-038 Reset SHALL override all inputs, including during an outstanding request; the memory sees imem_req fall and SHALL tolerate the abort.
REQ-039 The first imem_req after reset release SHALL occur in the second cycle after rst falls, with imem_addr=RESET_PC.

Verification
REQ-040 Reset release, imem_ack tied 1 -> imem_addr 0,4,8,12 on consecutive cycles; if_pc follows one cycle later with if_valid=1.
REQ-041 Ack with 2-cycle latency per fetch -> one if_valid=1 per 3 cycles; imem_addr stable through each wait.
REQ-042 stall_req_ex=1 for 3 cycles while acks continue -> stall=6'b001111; if_* frozen; one instruction skidded; imem_req=0 in HOLD; after release, the skidded PC is delivered next with no loss or duplicate.
REQ-043 branch_flag with branch_target=32'h00000100 while fetch at 0x0C is in flight -> 0x0C delivered (delay slot); next imem_addr=0x100.
REQ-044 flush with new_pc=32'h00000380 while request 0x20 is pending -> 0x20 data dropped (if_valid=0); next imem_addr=0x380; stall=0 in the flush cycle.
REQ-045 pc=32'hFFFFFFFC with ack -> next imem_addr=32'h00000000.
